// File: rtl/pc_branch_unit.sv
// ============================================================================
// pc_branch_unit : BIP-2 program-counter sequencer with branch decode and HLT
// Revision 1.0
// ============================================================================
`default_nettype none

module pc_branch_unit #(
  parameter int                    PC_WIDTH = 11,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  input  logic [4:0]          opcode_i,
  input  logic [PC_WIDTH-1:0] operand_i,
  input  logic                flags_we_i,
  input  logic                alu_zero_i,
  input  logic                alu_neg_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [PC_WIDTH-1:0] incrementer_o,
  output logic [PC_WIDTH-1:0] ext_o,
  output logic                branch_o,
  output logic                halted_o,
  output logic                flag_z_o,
  output logic                flag_n_o
);

  localparam logic [4:0] OP_HLT = 5'h00;
  localparam logic [4:0] OP_BEQ = 5'h08;
  localparam logic [4:0] OP_BNE = 5'h09;
  localparam logic [4:0] OP_BGT = 5'h0A;
  localparam logic [4:0] OP_BGE = 5'h0B;
  localparam logic [4:0] OP_BLT = 5'h0C;
  localparam logic [4:0] OP_BLE = 5'h0D;
  localparam logic [4:0] OP_JMP = 5'h0E;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc, pc_next, pc_inc;
  logic                flag_z, flag_n, flag_z_next, flag_n_next;
  logic                cond_true;
  logic                branch;

  assign pc_inc = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // Condition evaluation uses only the latched flags, so a branch sharing a
  // cycle with a flag write sees the previous instruction's status.
  always_comb begin
    cond_true = 1'b0;
    case (opcode_i)
      OP_BEQ:  cond_true = flag_z;
      OP_BNE:  cond_true = ~flag_z;
      OP_BGT:  cond_true = ~flag_z & ~flag_n;
      OP_BGE:  cond_true = ~flag_n;
      OP_BLT:  cond_true = flag_n;
      OP_BLE:  cond_true = flag_n | flag_z;
      OP_JMP:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign branch = (state == RUN) & cond_true;

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    flag_z_next = flag_z;
    flag_n_next = flag_n;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (en_i) begin
          if (opcode_i == OP_HLT) begin
            // PC parks on the HLT instruction itself.
            state_next = HALT;
          end else begin
            pc_next = branch ? operand_i : pc_inc;
          end
          if (flags_we_i) begin
            flag_z_next = alu_zero_i;
            flag_n_next = alu_neg_i;
          end
        end
      end
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      flag_z <= flag_z_next;
      flag_n <= flag_n_next;
    end
  end

  assign pc_o          = pc;
  assign incrementer_o = pc_inc;
  assign ext_o         = operand_i;
  assign branch_o      = branch;
  assign halted_o      = (state == HALT);
  assign flag_z_o      = flag_z;
  assign flag_n_o      = flag_n;

endmodule

`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
// ============================================================================
// tb_pc_branch_unit : scoreboard bench with directed + random instruction flow
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [4:0]  opcode = 5'h04;
  logic [10:0] operand = '0;
  logic        flags_we = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_neg = 1'b0;
  logic [10:0] pc, inc, ext;
  logic        branch, halted, fz, fn;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] pc;
    logic [10:0] inc;
    logic [10:0] ext;
    logic        br;
    logic        hl;
    logic        z;
    logic        n;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural view of the sequencer.
  int   m_pc = 0;
  bit   m_booting = 1'b1;
  bit   m_halted = 1'b0;
  bit   m_z = 1'b0;
  bit   m_n = 1'b0;
  bit   stim_done = 1'b0;

  pc_branch_unit #(.PC_WIDTH(11), .RESET_PC(11'd0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .opcode_i(opcode),
    .operand_i(operand), .flags_we_i(flags_we), .alu_zero_i(alu_zero),
    .alu_neg_i(alu_neg), .pc_o(pc), .incrementer_o(inc), .ext_o(ext),
    .branch_o(branch), .halted_o(halted), .flag_z_o(fz), .flag_n_o(fn)
  );

  always #5 clk = ~clk;

  function automatic bit taken(input int op, input bit z, input bit n);
    case (op)
      8:  return z;
      9:  return !z;
      10: return !z && !n;
      11: return !n;
      12: return n;
      13: return n || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle's inputs, queue the expected outputs, advance the model.
  task automatic cycle(input bit r, input bit e, input int op, input int opnd,
                       input bit we, input bit az, input bit an);
    bit   running, tk;
    exp_t x;
    rst_n = r; en = e; opcode = op[4:0]; operand = opnd[10:0];
    flags_we = we; alu_zero = az; alu_neg = an;
    if (!r) begin
      m_pc = 0; m_booting = 1; m_halted = 0; m_z = 0; m_n = 0;
    end
    #1;
    running = !m_booting && !m_halted;
    tk      = running && taken(op, m_z, m_n);
    x.pc  = m_pc[10:0];
    x.inc = 11'((m_pc + 1) % 2048);
    x.ext = opnd[10:0];
    x.br  = tk;
    x.hl  = m_halted;
    x.z   = m_z;
    x.n   = m_n;
    exp_q.push_back(x);
    if (r) begin
      if (m_booting) m_booting = 0;
      else if (running && e) begin
        if (op == 0) m_halted = 1;
        else m_pc = tk ? opnd : (m_pc + 1) % 2048;
        if (we) begin m_z = az; m_n = an; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: every negedge the DUT presents a full output set.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("pc_o", int'(pc), int'(x.pc));
        chk("incrementer_o", int'(inc), int'(x.inc));
        chk("ext_o", int'(ext), int'(x.ext));
        chk("branch_o", int'(branch), int'(x.br));
        chk("halted_o", int'(halted), int'(x.hl));
        chk("flag_z_o", int'(fz), int'(x.z));
        chk("flag_n_o", int'(fn), int'(x.n));
      end
    end
  end

  initial begin
    int op_tab[8];
    op_tab = '{4, 8, 9, 10, 11, 12, 13, 14};
    @(posedge clk);
    #1;
    // Reset then boot with ADD stream.
    cycle(0, 1, 4, 0, 0, 0, 0);
    cycle(0, 1, 4, 0, 0, 0, 0);
    cycle(1, 1, 4, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 4, 0, 0, 0, 0);
    // Wrap at the top of the address space.
    cycle(1, 1, 14, 2047, 0, 0, 0);
    cycle(1, 1, 4, 0, 0, 0, 0);
    cycle(1, 1, 4, 0, 0, 0, 0);
    // Conditional branches: Z=1 N=0.
    cycle(1, 1, 4, 0, 1, 1, 0);
    cycle(1, 1, 8, 8, 0, 0, 0);
    cycle(1, 1, 9, 20, 0, 0, 0);
    // Z=0 N=1.
    cycle(1, 1, 4, 0, 1, 0, 1);
    cycle(1, 1, 12, 14, 0, 0, 0);
    cycle(1, 1, 11, 30, 0, 0, 0);
    // BGT / BLE under every flag combination.
    for (int f = 0; f < 4; f++) begin
      cycle(1, 1, 4, 0, 1, f[0], f[1]);
      cycle(1, 1, 10, 100 + f, 0, 0, 0);
      cycle(1, 1, 13, 200 + f, 0, 0, 0);
    end
    // Flag/branch collision: old Z=0, BEQ writes Z=1.
    cycle(1, 1, 4, 0, 1, 0, 0);
    cycle(1, 1, 8, 300, 1, 1, 0);
    cycle(1, 1, 8, 400, 0, 0, 0);
    // Enable low: everything holds, even with flag writes and jumps offered.
    for (int i = 0; i < 3; i++) cycle(1, 0, 14, 77, 1, 0, 1);
    // Randomized instruction stream (no HLT).
    for (int i = 0; i < 300; i++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 31))
                                       : op_tab[$urandom_range(0, 7)];
      cycle(1, ($urandom_range(0, 5) != 0), op, int'($urandom_range(0, 2047)),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    // Halt at PC=5, then hammer it with JMP and flag writes.
    cycle(1, 1, 14, 5, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      cycle(1, i % 2, 14, 900 + i, 1, i % 2, (i / 2) % 2);
    // Halt at PC=11, then asynchronous reset between edges.
    cycle(0, 1, 4, 0, 0, 0, 0);
    cycle(1, 1, 4, 0, 0, 0, 0);
    cycle(1, 1, 14, 11, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 4, 0, 0, 0, 0);
    cycle(0, 1, 14, 33, 0, 0, 0);
    cycle(1, 1, 4, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 4, 0, 0, 0, 0);
    stim_done = 1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter sequencer for the BIP-2 core. Holds the 11-bit PC register and produces the two candidate next-PC values (`incrementer_o`, `ext_o`) plus the `branch_o` select that feeds the PC source mux. Evaluates conditional branches against latched ALU status flags and stops the core on HLT. Sits between the instruction decoder and the PC mux / program memory address port.

## Interface
- `PC_WIDTH`, 11, width of PC, operand and address buses
- `RESET_PC`, 11'd0, PC value loaded on reset
- `clk_i`  in  1  core clock, rising edge
- `rst_n_i`  in  1  asynchronous, active-low reset
- `en_i`  in  1  advance enable; PC and flags update only when 1
- `opcode_i`  in  5  current instruction opcode
- `operand_i`  in  PC_WIDTH  branch/jump target field of current instruction
- `flags_we_i`  in  1  ALU result valid; latch status flags this cycle
- `alu_zero_i`  in  1  ALU result == 0
- `alu_neg_i`  in  1  ALU result negative (MSB)
- `pc_o`  out  PC_WIDTH  current PC (program memory address)
- `incrementer_o`  out  PC_WIDTH  pc_o + 1, modulo 2^PC_WIDTH
- `ext_o`  out  PC_WIDTH  branch target (= operand_i)
- `branch_o`  out  1  1 = next PC taken from ext_o
- `halted_o`  out  1  core halted
- `flag_z_o`, `flag_n_o`  out  1 each  latched STATUS flags

## Operation
- States: BOOT, RUN, HALT.
  - BOOT: entered on reset; lasts exactly one cycle; PC held; goes to RUN unconditionally.
  - RUN: normal sequencing.
  - HALT: entered from RUN when `en_i`=1 and opcode = HLT (5'h00); left only by reset.
- Next PC in RUN with `en_i`=1: `branch_o` ? `ext_o` : `incrementer_o`. With `en_i`=0, PC, flags and state hold.
- `branch_o` is combinational, forced 0 outside RUN. In RUN it is decoded from `opcode_i` and the latched flags Z/N:
  - BEQ 5'h08: Z
  - BNE 5'h09: !Z
  - BGT 5'h0A: !Z & !N
  - BGE 5'h0B: !N
  - BLT 5'h0C: N
  - BLE 5'h0D: N | Z
  - JMP 5'h0E: 1
  - all other opcodes: 0
- `branch_o` does not depend on `en_i`.
- Flags Z/N load `alu_zero_i`/`alu_neg_i` when `en_i` & `flags_we_i` & state==RUN.
- A branch in the same cycle as `flags_we_i` uses the old flags; the new flags are visible from the next cycle.
- `incrementer_o` wraps: 2047 + 1 = 0. `ext_o` is passed through with no sign extension.
- In HALT: PC, flags and `halted_o`=1 are frozen regardless of `en_i`, `opcode_i` or `flags_we_i`.

## Timing
- Reset (async assert, any time, including mid-branch): `pc_o`=RESET_PC, `flag_z_o`=0, `flag_n_o`=0, `halted_o`=0, state=BOOT. `branch_o`=0 and `incrementer_o`=RESET_PC+1 immediately after reset.
- Deassertion is sampled at the next rising edge. The first edge after deassertion is BOOT→RUN with PC unchanged. The first PC change occurs on the second edge.
- Latency: one clock from `opcode_i`/`operand_i`/`en_i` valid to the new `pc_o`. No bubbles; a taken branch does not insert a stall cycle.
- `halted_o` rises on the edge that samples HLT with `en_i`=1. `pc_o` stays at the HLT address.
- Flags latch on the same edge as the PC update of the instruction that writes them.

## Test plan
- Reset/boot: hold `rst_n_i`=0, then release with `en_i`=1 and opcode ADD 5'h04. Required: `pc_o`=0 at reset, 0 after the first edge, then 1, 2, 3; `incrementer_o` = pc+1 each cycle.
- Wrap: force PC to 2047 via JMP with `operand_i`=11'd2047, then run ADD. Required: `pc_o` 2047 → 0, `branch_o`=0.
- Conditional branches: latch Z=1, N=0 (`flags_we_i`=1, `alu_zero_i`=1). Then:
  - BEQ with `operand_i`=8: `branch_o`=1, `pc_o`=8.
  - BNE with `operand_i`=20: `branch_o`=0, `pc_o`=9.
  - Latch Z=0, N=1; BLT with `operand_i`=14: `pc_o`=14.
  - BGE: falls through.
  - Repeat for BGT and BLE with all four Z/N combinations.
- Flag/branch collision: BEQ with `flags_we_i`=1, `alu_zero_i`=1, old Z=0. Required: not taken; `flag_z_o`=1 from the next cycle.
- Enable and halt: `en_i`=0 for 3 cycles. Required: `pc_o`, flags and state unchanged. Then HLT at PC=5. Required: `halted_o`=1, `pc_o`=5 for 10 cycles with JMP/`flags_we_i` applied, `branch_o`=0.
- Reset mid-operation: assert `rst_n_i`=0 asynchronously between edges while `pc_o`=11 and HALT. Required: `pc_o`=0 and `halted_o`=0 immediately, followed by BOOT and normal sequencing.
